// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC datapath: fold tags, angle scale and gain defaults.
package cordic_pkg;

  localparam logic [1:0] FOLD_NONE  = 2'b00;
  localparam logic [1:0] FOLD_NEG   = 2'b01;
  localparam logic [1:0] FOLD_ADDPI = 2'b10;
  localparam logic [1:0] FOLD_SUBPI = 2'b11;

  // Angles carry 2^ANGLE_FRAC units per radian.
  localparam int unsigned ANGLE_FRAC = 20;
  localparam int unsigned PI         = 3294199;
  localparam int unsigned PI_2       = 1647099;

  localparam int unsigned GW_DEF   = 17;
  localparam int unsigned FRAC_DEF = 16;
  localparam int unsigned GAIN_DEF = 39797;

endpackage

// File: rtl/cordic_gain_mul.sv
// Signed multiply by a fixed positive gain, round half up, drop FRAC bits and saturate.
module cordic_gain_mul #(
  parameter int unsigned DW   = 32,
  parameter int unsigned GW   = 17,
  parameter int unsigned FRAC = 16,
  parameter int unsigned GAIN = 39797
) (
  input  logic [DW-1:0] val_i,
  output logic [DW-1:0] res_o
);

  localparam int unsigned PW = DW + GW + 1;

  // Gain held as a non-negative GW+1 bit signed operand.
  localparam logic signed [GW:0]   GOP = (GW + 1)'(GAIN);
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] HI  = PW'({1'b0, {(DW - 1){1'b1}}});
  localparam logic signed [PW-1:0] LO  = ~HI;

  logic signed [PW-1:0] ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shf;

  always_comb begin
    ext  = PW'($signed(val_i));
    prod = ext * PW'(GOP);
    shf  = (prod + RND) >>> FRAC;
    if (shf > HI) begin
      res_o = HI[DW-1:0];
    end else if (shf < LO) begin
      res_o = LO[DW-1:0];
    end else begin
      res_o = shf[DW-1:0];
    end
  end

endmodule

// File: rtl/cordic_post.sv
// CORDIC output stage: undo quadrant fold (S1), then gain compensation (S2), valid/ready pipelined.
module cordic_post #(
  parameter int unsigned DW   = 32,
  parameter int unsigned GW   = cordic_pkg::GW_DEF,
  parameter int unsigned FRAC = cordic_pkg::FRAC_DEF,
  parameter int unsigned GAIN = cordic_pkg::GAIN_DEF,
  parameter int unsigned PI   = cordic_pkg::PI
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [1:0]    i_fold,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] y_i,
  input  logic [DW-1:0] z_i,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] x_o,
  output logic [DW-1:0] y_o,
  output logic [DW-1:0] z_o
);

  import cordic_pkg::*;

  localparam logic [DW-1:0] SMAX = {1'b0, {(DW - 1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW - 1){1'b0}}};
  localparam logic [DW-1:0] ZPI  = DW'(PI);

  function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] v);
    return (v == SMIN) ? SMAX : -v;
  endfunction

  logic          s1_v;
  logic [DW-1:0] s1_x, s1_y, s1_z;
  logic [DW-1:0] fx, fy, fz;
  logic [DW-1:0] gx, gy;
  logic          s1_en, s2_en;

  assign s2_en   = ~o_valid | o_ready;
  assign s1_en   = ~s1_v | s2_en;
  assign i_ready = s1_en;

  always_comb begin
    fx = x_i;
    fy = y_i;
    fz = z_i;
    case (i_fold)
      FOLD_NEG: begin
        fx = neg_sat(x_i);
        fy = neg_sat(y_i);
      end
      // Angle corrections wrap modulo 2^DW on purpose.
      FOLD_ADDPI: fz = z_i + ZPI;
      FOLD_SUBPI: fz = z_i - ZPI;
      default: ;
    endcase
  end

  cordic_gain_mul #(
    .DW  (DW),
    .GW  (GW),
    .FRAC(FRAC),
    .GAIN(GAIN)
  ) u_gain_x (
    .val_i(s1_x),
    .res_o(gx)
  );

  cordic_gain_mul #(
    .DW  (DW),
    .GW  (GW),
    .FRAC(FRAC),
    .GAIN(GAIN)
  ) u_gain_y (
    .val_i(s1_y),
    .res_o(gy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_z    <= '0;
      o_valid <= 1'b0;
      x_o     <= '0;
      y_o     <= '0;
      z_o     <= '0;
    end else begin
      if (s1_en) begin
        s1_v <= i_valid;
        if (i_valid) begin
          s1_x <= fx;
          s1_y <= fy;
          s1_z <= fz;
        end
      end
      if (s2_en) begin
        o_valid <= s1_v;
        if (s1_v) begin
          x_o <= gx;
          y_o <= gy;
          z_o <= s1_z;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_post.sv
// Self-checking bench for cordic_post: vector table, backpressure, reset and random streaming.
module tb_cordic_post;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [1:0]  i_fold;
  logic [31:0] x_i, y_i, z_i;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] x_o, y_o, z_o;

  always #5 clk = ~clk;

  cordic_post u_dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_fold (i_fold),
    .x_i    (x_i),
    .y_i    (y_i),
    .z_i    (z_i),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .x_o    (x_o),
    .y_o    (y_o),
    .z_o    (z_o)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } beat_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [1:0]  fold;
    logic [31:0] ex;
    logic [31:0] ey;
    logic [31:0] ez;
  } vec_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic logic [31:0] gain_ref(input logic [31:0] v);
    longint p;
    p = longint'($signed(v)) * 64'sd39797;
    p = (p + 64'sd32768) >>> 16;
    if (p > 64'sd2147483647) p = 64'sd2147483647;
    if (p < -64'sd2147483648) p = -64'sd2147483648;
    return p[31:0];
  endfunction

  function automatic beat_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] z, input logic [1:0] fold);
    beat_t b;
    logic [31:0] nx, ny, nz;
    nx = x;
    ny = y;
    nz = z;
    if (fold == 2'b01) begin
      nx = (x == 32'h8000_0000) ? 32'h7fff_ffff : 32'd0 - x;
      ny = (y == 32'h8000_0000) ? 32'h7fff_ffff : 32'd0 - y;
    end else if (fold == 2'b10) begin
      nz = z + 32'd3294199;
    end else if (fold == 2'b11) begin
      nz = z - 32'd3294199;
    end
    b.x = gain_ref(nx);
    b.y = gain_ref(ny);
    b.z = nz;
    return b;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Called with inputs already driven; resolves this edge's handshakes, then advances.
  task automatic tick();
    beat_t e;
    #1;
    if (o_valid && !o_ready && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("stall_hold", {x_o, y_o, z_o}, {e.x, e.y, e.z});
    end
    if (o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h %h %h want none", x_o, y_o, z_o);
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", {x_o, y_o, z_o}, {e.x, e.y, e.z});
      end
    end
    if (i_valid && i_ready && !rst) exp_q.push_back(model(x_i, y_i, z_i, i_fold));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                       input logic [1:0] f);
    i_valid = 1'b1;
    x_i     = x;
    y_i     = y;
    z_i     = z;
    i_fold  = f;
  endtask

  task automatic drain(input string name);
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) tick();
    chk(name, 96'(exp_q.size()), 96'd0);
    exp_q.delete();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'd1048576, -32'sd1048576, 32'd5, 2'b00, 32'd636752, -32'sd636752, 32'd5};
    vecs[1] = '{32'h8000_0000, 32'd0, 32'd0, 2'b01, 32'd1304068095, 32'd0, 32'd0};
    vecs[2] = '{32'd0, 32'd0, -32'sd1000000, 2'b10, 32'd0, 32'd0, 32'd2294199};
    vecs[3] = '{32'd0, 32'd0, 32'd2147482647, 2'b10, 32'd0, 32'd0, 32'h8000_0000 + 32'd3293198};
    vecs[4] = '{32'd0, 32'd0, 32'd2147482648, 2'b10, 32'd0, 32'd0, 32'h8000_0000 + 32'd3293199};
    vecs[5] = '{32'd0, 32'd0, 32'd0, 2'b11, 32'd0, 32'd0, -32'sd3294199};
    vecs[6] = '{32'd3, -32'sd3, 32'd7, 2'b00, 32'd2, -32'sd2, 32'd7};
    vecs[7] = '{32'd100, 32'd0, 32'd9, 2'b01, -32'sd61, 32'd0, 32'd9};

    rst     = 1'b1;
    i_valid = 1'b0;
    i_fold  = 2'b00;
    x_i     = '0;
    y_i     = '0;
    z_i     = '0;
    o_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_state", {63'd0, o_valid, x_o, i_ready}, {63'd0, 1'b0, 32'd0, 1'b1});
    chk("reset_yz", {32'd0, y_o, z_o}, 96'd0);

    // Table vectors: expected values are hand-derived constants, not the model.
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].fold);
      #1;
      chk("model_vs_table", {model(vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].fold).x,
                             model(vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].fold).y,
                             model(vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].fold).z},
          {vecs[v].ex, vecs[v].ey, vecs[v].ez});
      tick();
    end
    drain("table_drain");

    // Latency: single beat appears exactly two edges after acceptance.
    drive(32'd1048576, 32'd0, 32'd1, 2'b00);
    tick();
    i_valid = 1'b0;
    tick();
    chk("latency_2", 96'(o_valid), 96'd1);
    drain("latency_drain");

    // Backpressure: A and B fill the pipe, C is held off.
    o_ready = 1'b0;
    drive(32'd1000, 32'd2000, 32'd1, 2'b00);
    tick();
    drive(32'd3000, 32'd4000, 32'd2, 2'b01);
    tick();
    drive(32'd5000, 32'd6000, 32'd3, 2'b10);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready_low", 96'(i_ready), 96'd0);
      tick();
    end
    o_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    drain("bp_drain");

    // Reset with two beats in flight.
    o_ready = 1'b0;
    drive(32'd11, 32'd22, 32'd33, 2'b00);
    tick();
    drive(32'd44, 32'd55, 32'd66, 2'b00);
    tick();
    i_valid = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_state", {63'd0, o_valid, x_o, i_ready}, {63'd0, 1'b0, 32'd0, 1'b1});
    chk("midrst_yz", {32'd0, y_o, z_o}, 96'd0);
    o_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("midrst_no_out", 96'(o_valid), 96'd0);
      tick();
    end

    // Random streaming with continuous output.
    for (int k = 0; k < 100; k++) begin
      drive($urandom(), $urandom(), $urandom(), 2'($urandom_range(0, 3)));
      if (k % 17 == 0) x_i = 32'h8000_0000;
      #1;
      if (k >= 2) chk("stream_valid", 96'(o_valid), 96'd1);
      tick();
    end
    drain("stream_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
